// File: rtl/core_types_pkg.sv
// Shared core types for the memory stage: request/writeback control, LSU state,
// access length and the registered data-memory bus request.
package core_types_pkg;

   localparam int unsigned N_BITS = 32;

   typedef struct packed {
      logic       vld;
      logic       mtype;  // 0 = load, 1 = store
      logic [1:0] len;    // B/H/W, 3 is illegal
   } dmem_req_ctrl_t;

   typedef struct packed {
      logic [4:0] rd;
      logic       wr_en;
   } rf_ctrl_t;

   typedef enum logic [1:0] {
      MEM_LEN_B = 2'd0,
      MEM_LEN_H = 2'd1,
      MEM_LEN_W = 2'd2
   } mem_len_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } lsu_state_e;

   typedef struct packed {
      logic [N_BITS-1:0] addr;
      logic              we;
      logic [3:0]        wstrb;
      logic [N_BITS-1:0] wdata;
   } dmem_bus_req_t;

endpackage

// File: rtl/dmem_align.sv
// Combinational data alignment: misalign check and store lane formatting for the
// incoming request, byte-lane extraction and extension for the returning load word.
module dmem_align
   import core_types_pkg::*;
(
   input  logic [1:0]        req_len_i,
   input  logic [1:0]        req_off_i,
   input  logic [N_BITS-1:0] req_wdata_i,
   output logic              misalign_o,
   output logic [3:0]        wstrb_o,
   output logic [N_BITS-1:0] wdata_o,
   input  logic [1:0]        ld_len_i,
   input  logic [1:0]        ld_off_i,
   input  logic              ld_unsigned_i,
   input  logic [N_BITS-1:0] rdata_i,
   output logic [N_BITS-1:0] ld_data_o
);

   logic [N_BITS-1:0] shifted;
   logic              sext;

   always_comb begin
      misalign_o = 1'b0;
      wstrb_o    = 4'h0;
      wdata_o    = req_wdata_i;
      case (req_len_i)
         MEM_LEN_B: begin
            wstrb_o = 4'b0001 << req_off_i;
            wdata_o = {4{req_wdata_i[7:0]}};
         end
         MEM_LEN_H: begin
            misalign_o = req_off_i[0];
            wstrb_o    = 4'b0011 << req_off_i;
            wdata_o    = {2{req_wdata_i[15:0]}};
         end
         MEM_LEN_W: begin
            misalign_o = |req_off_i;
            wstrb_o    = 4'hF;
         end
         default: misalign_o = 1'b1;
      endcase
   end

   always_comb begin
      shifted = rdata_i >> {ld_off_i, 3'b000};
      sext    = ~ld_unsigned_i;
      case (ld_len_i)
         MEM_LEN_B: ld_data_o = {{24{sext & shifted[7]}}, shifted[7:0]};
         MEM_LEN_H: ld_data_o = {{16{sext & shifted[15]}}, shifted[15:0]};
         default:   ld_data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// Memory-stage load/store unit: one valid/ready bus transaction per request,
// pipeline stall until completion, aligned load writeback and misalign exception.
module dmem_lsu
   import core_types_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  dmem_req_ctrl_t    req_ctrl_i,
   input  logic              req_unsigned_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [N_BITS-1:0] req_wdata_i,
   input  rf_ctrl_t          req_rf_i,
   output logic              stall_o,
   output logic              mem_req_vld_o,
   input  logic              mem_req_rdy_i,
   output logic [ADDR_W-1:0] mem_req_addr_o,
   output logic              mem_req_we_o,
   output logic [3:0]        mem_req_wstrb_o,
   output logic [N_BITS-1:0] mem_req_wdata_o,
   input  logic              mem_resp_vld_i,
   input  logic [N_BITS-1:0] mem_resp_rdata_i,
   output rf_ctrl_t          wb_o,
   output logic [N_BITS-1:0] wb_data_o,
   output logic              misalign_o
);

   lsu_state_e        state_q;
   dmem_bus_req_t     bus_q;
   logic [1:0]        len_q;
   logic [1:0]        off_q;
   logic              uns_q;
   rf_ctrl_t          rf_q;
   rf_ctrl_t          wb_q;
   logic [N_BITS-1:0] wb_data_q;
   logic              misalign_q;

   logic              misalign;
   logic [3:0]        fmt_wstrb;
   logic [N_BITS-1:0] fmt_wdata;
   logic [N_BITS-1:0] ld_data;
   logic              done;

   dmem_align u_align (
      .req_len_i     (req_ctrl_i.len),
      .req_off_i     (req_addr_i[1:0]),
      .req_wdata_i   (req_wdata_i),
      .misalign_o    (misalign),
      .wstrb_o       (fmt_wstrb),
      .wdata_o       (fmt_wdata),
      .ld_len_i      (len_q),
      .ld_off_i      (off_q),
      .ld_unsigned_i (uns_q),
      .rdata_i       (mem_resp_rdata_i),
      .ld_data_o     (ld_data)
   );

   always_comb begin
      done = 1'b0;
      unique case (state_q)
         IDLE:    done = req_ctrl_i.vld & misalign;
         REQ:     done = mem_req_rdy_i & bus_q.we;
         RESP:    done = mem_resp_vld_i;
         default: done = 1'b0;
      endcase
   end

   // Upstream holds the request while stalled; releasing in the done cycle lets it
   // advance on the next edge.
   assign stall_o = req_ctrl_i.vld & ~done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         bus_q      <= '0;
         len_q      <= 2'd0;
         off_q      <= 2'd0;
         uns_q      <= 1'b0;
         rf_q       <= '0;
         wb_q       <= '0;
         wb_data_q  <= '0;
         misalign_q <= 1'b0;
      end else begin
         wb_q.wr_en <= 1'b0;
         misalign_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (req_ctrl_i.vld) begin
                  if (misalign) begin
                     misalign_q <= 1'b1;
                  end else begin
                     state_q     <= REQ;
                     bus_q.addr  <= N_BITS'({req_addr_i[ADDR_W-1:2], 2'b00});
                     bus_q.we    <= req_ctrl_i.mtype;
                     bus_q.wstrb <= req_ctrl_i.mtype ? fmt_wstrb : 4'h0;
                     bus_q.wdata <= fmt_wdata;
                     len_q       <= req_ctrl_i.len;
                     off_q       <= req_addr_i[1:0];
                     uns_q       <= req_unsigned_i;
                     rf_q        <= req_rf_i;
                  end
               end
            end
            REQ: begin
               if (mem_req_rdy_i) begin
                  state_q <= bus_q.we ? IDLE : RESP;
               end
            end
            RESP: begin
               if (mem_resp_vld_i) begin
                  state_q    <= IDLE;
                  wb_data_q  <= ld_data;
                  wb_q.rd    <= rf_q.rd;
                  wb_q.wr_en <= rf_q.wr_en;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_req_vld_o   = (state_q == REQ);
   assign mem_req_addr_o  = bus_q.addr[ADDR_W-1:0];
   assign mem_req_we_o    = bus_q.we;
   assign mem_req_wstrb_o = bus_q.wstrb;
   assign mem_req_wdata_o = bus_q.wdata;
   assign wb_o            = wb_q;
   assign wb_data_o       = wb_data_q;
   assign misalign_o      = misalign_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed cases plus randomized transactions against a
// behavioural model of bus formatting, load extension, stall and pulse timing.
module tb_dmem_lsu;
   import core_types_pkg::*;

   logic           clk;
   logic           rst_n;
   dmem_req_ctrl_t req_ctrl;
   logic           req_unsigned;
   logic [31:0]    req_addr;
   logic [31:0]    req_wdata;
   rf_ctrl_t       req_rf;
   logic           stall;
   logic           mem_req_vld;
   logic           mem_req_rdy;
   logic [31:0]    mem_req_addr;
   logic           mem_req_we;
   logic [3:0]     mem_req_wstrb;
   logic [31:0]    mem_req_wdata;
   logic           mem_resp_vld;
   logic [31:0]    mem_resp_rdata;
   rf_ctrl_t       wb;
   logic [31:0]    wb_data;
   logic           misalign;

   int n_checks = 0;
   int n_errors = 0;
   int n_acc    = 0;

   logic        exp_wb_en   = 1'b0;
   logic        exp_mis     = 1'b0;
   logic        exp_ld_done = 1'b0;
   logic [31:0] exp_wb_data = '0;
   logic [4:0]  exp_rd      = '0;

   dmem_lsu #(.ADDR_W(32)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .req_ctrl_i       (req_ctrl),
      .req_unsigned_i   (req_unsigned),
      .req_addr_i       (req_addr),
      .req_wdata_i      (req_wdata),
      .req_rf_i         (req_rf),
      .stall_o          (stall),
      .mem_req_vld_o    (mem_req_vld),
      .mem_req_rdy_i    (mem_req_rdy),
      .mem_req_addr_o   (mem_req_addr),
      .mem_req_we_o     (mem_req_we),
      .mem_req_wstrb_o  (mem_req_wstrb),
      .mem_req_wdata_o  (mem_req_wdata),
      .mem_resp_vld_i   (mem_resp_vld),
      .mem_resp_rdata_i (mem_resp_rdata),
      .wb_o             (wb),
      .wb_data_o        (wb_data),
      .misalign_o       (misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst_n && mem_req_vld && mem_req_rdy) n_acc <= n_acc + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got %h, required %h", tag, act, expv);
      end
   endtask

   // Pulses due from the previous cycle's completion; cleared so the next call sees 0.
   task automatic check_pulses();
      check_val("wb_wr_en", wb.wr_en, exp_wb_en);
      check_val("misalign", misalign, exp_mis);
      if (exp_ld_done) begin
         check_val("wb_data", wb_data, exp_wb_data);
         check_val("wb_rd", wb.rd, exp_rd);
      end
      exp_wb_en   = 1'b0;
      exp_mis     = 1'b0;
      exp_ld_done = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      check_val({tag, "_req_vld"}, mem_req_vld, 0);
      check_val({tag, "_req_we"}, mem_req_we, 0);
      check_val({tag, "_req_wstrb"}, mem_req_wstrb, 0);
      check_val({tag, "_req_addr"}, mem_req_addr, 0);
      check_val({tag, "_req_wdata"}, mem_req_wdata, 0);
      check_val({tag, "_wb_en"}, wb.wr_en, 0);
      check_val({tag, "_wb_rd"}, wb.rd, 0);
      check_val({tag, "_wb_data"}, wb_data, 0);
      check_val({tag, "_misalign"}, misalign, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check_pulses();
         check_val("idle_req_vld", mem_req_vld, 0);
         req_ctrl.vld   = 1'b0;
         mem_req_rdy    = 1'($urandom_range(0, 1));
         mem_resp_vld   = 1'($urandom_range(0, 1));
         mem_resp_rdata = $urandom;
         #1 check_val("idle_stall", stall, 0);
      end
   endtask

   task automatic txn(input logic st, input logic [1:0] len, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic uns, input logic [4:0] rd,
                      input logic rd_en, input int rdy_dly, input int resp_dly,
                      input logic [31:0] rdata);
      logic        mis;
      logic [31:0] e_strb, e_wdata, e_ld;
      int          off;
      off = int'(addr[1:0]);
      @(negedge clk);
      check_pulses();
      check_val("start_req_vld", mem_req_vld, 0);
      req_ctrl.vld   = 1'b1;
      req_ctrl.mtype = st;
      req_ctrl.len   = len;
      req_addr       = addr;
      req_wdata      = wdata;
      req_unsigned   = uns;
      req_rf.rd      = rd;
      req_rf.wr_en   = rd_en;
      mem_req_rdy    = 1'b0;
      mem_resp_vld   = 1'b0;
      #1;
      mis = (len == 2'd3) || (len == 2'd1 && off % 2 != 0) || (len == 2'd2 && off != 0);
      if (mis) begin
         check_val("mis_stall", stall, 0);
         exp_mis = 1'b1;
         return;
      end
      check_val("c0_stall", stall, 1);
      if (!st)              e_strb = 0;
      else if (len == 2'd0) e_strb = 32'd1 << off;
      else if (len == 2'd1) e_strb = 32'd3 << off;
      else                  e_strb = 32'd15;
      if (len == 2'd0)      e_wdata = (wdata & 32'hFF) * 32'h0101_0101;
      else if (len == 2'd1) e_wdata = (wdata & 32'hFFFF) * 32'h0001_0001;
      else                  e_wdata = wdata;
      for (int k = 0; k <= rdy_dly; k++) begin
         @(negedge clk);
         check_pulses();
         check_val("req_vld", mem_req_vld, 1);
         check_val("req_addr", mem_req_addr, addr & ~32'd3);
         check_val("req_we", mem_req_we, st);
         check_val("req_wstrb", mem_req_wstrb, e_strb);
         if (st) check_val("req_wdata", mem_req_wdata, e_wdata);
         mem_req_rdy = (k == rdy_dly);
         #1 check_val("req_stall", stall, (st && k == rdy_dly) ? 0 : 1);
      end
      if (st) return;
      for (int j = 0; j <= resp_dly; j++) begin
         @(negedge clk);
         check_pulses();
         check_val("resp_req_vld", mem_req_vld, 0);
         mem_req_rdy    = 1'b0;
         mem_resp_vld   = (j == resp_dly);
         mem_resp_rdata = (j == resp_dly) ? rdata : $urandom;
         #1 check_val("resp_stall", stall, (j == resp_dly) ? 0 : 1);
      end
      if (len == 2'd0) begin
         e_ld = (rdata >> (8 * off)) & 32'hFF;
         if (!uns && e_ld >= 32'd128) e_ld = e_ld - 32'd256;
      end else if (len == 2'd1) begin
         e_ld = (rdata >> (8 * off)) & 32'hFFFF;
         if (!uns && e_ld >= 32'd32768) e_ld = e_ld - 32'd65536;
      end else begin
         e_ld = rdata;
      end
      exp_wb_en   = rd_en;
      exp_wb_data = e_ld;
      exp_rd      = rd;
      exp_ld_done = 1'b1;
   endtask

   initial begin
      int          n0;
      logic [1:0]  rlen;
      int          r;
      rst_n          = 1'b0;
      req_ctrl       = '0;
      req_unsigned   = 1'b0;
      req_addr       = '0;
      req_wdata      = '0;
      req_rf         = '0;
      mem_req_rdy    = 1'b0;
      mem_resp_vld   = 1'b0;
      mem_resp_rdata = '0;
      #1 check_reset("rst");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);

      // Directed cases
      txn(1'b1, 2'd0, 32'h0000_1003, 32'h0000_00A5, 1'b0, 5'd0, 1'b0, 0, 0, 32'h0);
      txn(1'b0, 2'd0, 32'h0000_2001, 32'h0, 1'b0, 5'd7, 1'b1, 0, 0, 32'h0000_8000);
      txn(1'b0, 2'd0, 32'h0000_2001, 32'h0, 1'b1, 5'd9, 1'b1, 0, 0, 32'h0000_8000);
      txn(1'b0, 2'd1, 32'h0000_0002, 32'h0, 1'b0, 5'd3, 1'b1, 0, 0, 32'h8001_1234);
      txn(1'b0, 2'd2, 32'h0000_0004, 32'h0, 1'b0, 5'd12, 1'b1, 3, 1, 32'hDEAD_BEEF);
      txn(1'b1, 2'd2, 32'h0000_0006, 32'h1234_5678, 1'b0, 5'd0, 1'b0, 0, 0, 32'h0);
      txn(1'b0, 2'd1, 32'h0000_0001, 32'h0, 1'b0, 5'd4, 1'b1, 0, 0, 32'h0);
      txn(1'b0, 2'd3, 32'h0000_0000, 32'h0, 1'b0, 5'd4, 1'b1, 0, 0, 32'h0);
      idle(1);

      // Back-to-back load then store
      n0 = n_acc;
      txn(1'b0, 2'd2, 32'h0000_0100, 32'h0, 1'b0, 5'd21, 1'b1, 0, 0, 32'hCAFE_F00D);
      txn(1'b1, 2'd2, 32'h0000_0104, 32'h5555_AAAA, 1'b0, 5'd22, 1'b1, 0, 0, 32'h0);
      idle(2);
      check_val("b2b_acc", n_acc - n0, 2);

      // Reset while waiting for a load response
      @(negedge clk);
      check_pulses();
      req_ctrl.vld   = 1'b1;
      req_ctrl.mtype = 1'b0;
      req_ctrl.len   = 2'd2;
      req_addr       = 32'h0000_0040;
      req_rf.rd      = 5'd5;
      req_rf.wr_en   = 1'b1;
      mem_req_rdy    = 1'b0;
      mem_resp_vld   = 1'b0;
      @(negedge clk);
      mem_req_rdy = 1'b1;
      @(negedge clk);
      mem_req_rdy  = 1'b0;
      rst_n        = 1'b0;
      req_ctrl.vld = 1'b0;
      #1 check_reset("rst_mid");
      @(negedge clk);
      rst_n          = 1'b1;
      mem_resp_vld   = 1'b1;
      mem_resp_rdata = 32'h1357_9BDF;
      @(negedge clk);
      mem_resp_vld = 1'b0;
      check_reset("rst_late");
      idle(1);

      // Randomized transactions
      for (int t = 0; t < 150; t++) begin
         r = $urandom_range(0, 9);
         rlen = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
         txn(1'($urandom_range(0, 1)), rlen, $urandom, $urandom, 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit at the memory stage of the core. Consumes the execute stage's `dmem_req_ctrl_t` request, address and store data, runs one transaction on a valid/ready data-memory bus, and stalls the pipeline until the transaction completes. It aligns and sign-extends load data, returns it with the `rf_ctrl_t` destination for writeback, and flags misaligned accesses without touching the bus.

## Interface
- Parameters:
- `ADDR_W`, 32: byte address width.
- `N_BITS`, 32 (package): data width. Only 32 is supported.
- Ports:
- `clk`  in  1  core clock; all state is posedge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req_ctrl_i`  in  `dmem_req_ctrl_t`  `vld`; `mtype` (0=load, 1=store); `len` (0=B, 1=H, 2=W, 3=illegal).
- `req_unsigned_i`  in  1  load zero-extends (LBU/LHU).
- `req_addr_i`  in  ADDR_W  effective byte address.
- `req_wdata_i`  in  32  store data, right-justified.
- `req_rf_i`  in  `rf_ctrl_t`  load destination.
- `stall_o`  out  1  hold the request and upstream stages.
- `mem_req_vld_o`  out  1  bus request valid.
- `mem_req_rdy_i`  in  1  bus request accepted.
- `mem_req_addr_o`  out  ADDR_W  word-aligned address, `[1:0]`=0.
- `mem_req_we_o`  out  1  write.
- `mem_req_wstrb_o`  out  4  byte enables.
- `mem_req_wdata_o`  out  32  lane-replicated store data.
- `mem_resp_vld_i`  in  1  read data valid.
- `mem_resp_rdata_i`  in  32  read word.
- `wb_o`  out  `rf_ctrl_t`  writeback `rd`/`wr_en`; `wr_en` is a 1-cycle pulse.
- `wb_data_o`  out  32  extended load data.
- `misalign_o`  out  1  1-cycle exception pulse.

## Operation
- Upstream contract: `req_*` stays stable while `stall_o`=1. The LSU uses its own captured copy after the IDLE cycle.
- FSM `lsu_state_e`:
  - IDLE: if `req_ctrl_i.vld`:
    - Misaligned request (H with addr[0]=1, W with addr[1:0]≠0, or len=3): done this cycle, `misalign_o` pulses next cycle, state stays IDLE.
    - Otherwise capture addr, `mtype`, `len`, unsigned flag, rf and formatted wdata/wstrb, then go to REQ.
  - REQ: `mem_req_vld_o`=1 and fields are driven from the capture registers. On `mem_req_rdy_i`:
    - Store: done, go to IDLE.
    - Load: go to RESP.
  - RESP: wait for `mem_resp_vld_i`. Then done, go to IDLE, register the extended data, and set `wb_o.wr_en` = captured `wr_en` for one cycle.
- `stall_o` = `req_ctrl_i.vld` & ~done (combinational). It drops in the completion cycle, so upstream advances on the next edge and a new request is seen in IDLE.
- Store formatting:
  - B: wstrb = 4'b0001<<addr[1:0], wdata={4{d[7:0]}}.
  - H: wstrb = 4'b0011<<addr[1:0], wdata={2{d[15:0]}}.
  - W: wstrb = 4'hF, wdata = d.
- Load extraction: byte lane = rdata>>(8·addr[1:0]). Sign-extend from bit 7 (B) or bit 15 (H) unless unsigned; W passes through.
- Loads are always issued with wstrb=0. `mem_resp_vld_i` is ignored outside RESP.

## Timing
- Reset values: state IDLE. `mem_req_vld_o`, `mem_req_we_o`, `wb_o.wr_en` and `misalign_o` are 0. `mem_req_wstrb_o`, `mem_req_addr_o`, `mem_req_wdata_o`, `wb_data_o` and `wb_o.rd` are 0.
- Request cycle C0 (IDLE): `mem_req_vld_o` rises at C1.
- Store with rdy=1 at C1: best-case occupancy 2 cycles, `stall_o` low in C1.
- Load with rdy at C1 and resp at C2: `wb_o.wr_en`/`wb_data_o` valid in C3. Minimum 3 cycles request-to-writeback.
- `mem_req_vld_o` stays asserted with stable fields until rdy; it is never withdrawn.
- Back-to-back: the next request is captured in the cycle after completion. There is no overlap and at most one transaction outstanding.
- Reset asserted mid-transaction returns to IDLE immediately. A late response after reset is dropped.

## Structure
- Add to `core_types_pkg`:
  - `lsu_state_e` (IDLE/REQ/RESP).
  - `mem_len_e` (MEM_LEN_B=0, H=1, W=2).
  - `dmem_bus_req_t` struct (addr, we, wstrb, wdata).
- Sub-module `dmem_align`: purely combinational. Produces the misalign check, wstrb/wdata formatting and load extract/extend. The FSM and capture registers live in `dmem_lsu`.

## Test plan
- SB addr 0x1003, wdata 0xA5 → `mem_req_addr_o`=0x1000, wstrb=4'b1000, wdata=0xA5A5A5A5, we=1. `stall_o` high C0 only (rdy=1 at C1).
- LB addr 0x2001, rdata 0x0000_8000, unsigned=0 → `wb_data_o`=0xFFFF_FF80. With unsigned=1 → 0x0000_0080. `wr_en` pulses once, rd matches.
- LH addr 0x0002, rdata 0x8001_1234 → 0xFFFF_8001. LW addr 0x0004 with rdy held low 3 cycles → `mem_req_vld_o` and fields stable throughout, `stall_o` held.
- SW addr 0x0006 → `misalign_o` pulse next cycle, no `mem_req_vld_o`, `stall_o` never asserted. LH addr 0x0001 and len=3 also raise `misalign_o`.
- LW then SW back-to-back (rdy/resp immediate) → exactly two bus requests, no duplicate re-issue, writeback only for the load.
- `rst_n` low while in RESP, then resp arrives after release → FSM in IDLE, no `wr_en`, all outputs at reset values.
